fifo_sc_wc: RTL and testbench

- Single-clock FIFO with power-of-two width conversion between write and read sides.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Programmable almost-full and almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Serves as the same-domain counterpart of the team's dual-clock FIFO in datapath packing/unpacking stages.

---
 rtl/fifo_sc_wc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fifo_sc_wc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sc_wc.sv
// -----------------------------------------------------------------------------
// fifo_sc_wc -- single-clock FIFO with power-of-two width conversion
//
// Purpose:
//   Same-clock FIFO used in datapath packing/unpacking stages. The write and
//   read word widths may differ by a power-of-two ratio in either direction.
//   Narrow writes are packed little-endian into wide read words. Wide writes
//   are unpacked lowest slice first. The read side runs either as a standard
//   registered read or as first-word-fall-through (FWFT).
//
// Parameters:
//   I_WIDTH   write word width (bits, multiple of 8)
//   I_DEPTH   capacity in write words (power of two, >= 2)
//   O_WIDTH   read word width (bits, power-of-two ratio to I_WIDTH)
//   O_DEPTH   capacity in read words (I_WIDTH*I_DEPTH == O_WIDTH*O_DEPTH)
//   FWFT      0 = registered read, 1 = first-word-fall-through
//   AF_LEVEL  almost-full threshold: wr_afull_o when wr_free_o <= I_DEPTH-AF_LEVEL
//   AE_LEVEL  almost-empty threshold: rd_aempty_o when rd_avail_o <= AE_LEVEL
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset (overrides flush_i)
//   flush_i      synchronous clear of pointers and error flags
//   wr_en_i      write request
//   wr_data_i    write data [I_WIDTH]
//   wr_full_o    no room for one write word
//   wr_free_o    free space in write words
//   wr_afull_o   almost full
//   rd_en_i      read request (FWFT: pop the head word)
//   rd_data_o    read data [O_WIDTH]
//   rd_valid_o   rd_data_o holds valid data
//   rd_empty_o   no complete read word stored
//   rd_avail_o   complete read words stored
//   rd_aempty_o  almost empty
//   overflow_o   sticky: write attempted while full
//   underflow_o  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sc_wc #(
  parameter int I_WIDTH  = 8,
  parameter int I_DEPTH  = 16,
  parameter int O_WIDTH  = 32,
  parameter int O_DEPTH  = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = I_DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [I_WIDTH-1:0]         wr_data_i,
  output logic                       wr_full_o,
  output logic [$clog2(I_DEPTH):0]   wr_free_o,
  output logic                       wr_afull_o,
  input  logic                       rd_en_i,
  output logic [O_WIDTH-1:0]         rd_data_o,
  output logic                       rd_valid_o,
  output logic                       rd_empty_o,
  output logic [$clog2(O_DEPTH):0]   rd_avail_o,
  output logic                       rd_aempty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  // ---------------------------------------------------------------------------
  // Geometry. Storage is addressed in slots of the narrower width. Physically
  // it is split into LANES banks of narrow slots so a wide access touches one
  // row across all banks, and a narrow access touches one bank.
  // ---------------------------------------------------------------------------
  localparam int NW     = (I_WIDTH < O_WIDTH) ? I_WIDTH : O_WIDTH;
  localparam int WW     = (I_WIDTH < O_WIDTH) ? O_WIDTH : I_WIDTH;
  localparam int LANES  = WW / NW;
  localparam int N      = (I_DEPTH > O_DEPTH) ? I_DEPTH : O_DEPTH;
  localparam int D      = N / LANES;
  localparam int PW     = $clog2(N) + 1;
  localparam int AW     = (D > 1) ? $clog2(D) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WR_SH  = $clog2(I_WIDTH / NW);
  localparam int RD_SH  = $clog2(O_WIDTH / NW);
  localparam int FW     = $clog2(I_DEPTH) + 1;
  localparam int AVW    = $clog2(O_DEPTH) + 1;

  localparam logic [PW-1:0] WR_STEP = PW'(I_WIDTH / NW);
  localparam logic [PW-1:0] RD_STEP = PW'(O_WIDTH / NW);
  localparam logic [PW-1:0] N_SLOTS = PW'(N);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic           overflow_reg, overflow_next;
  logic           underflow_reg, underflow_next;

  // ---------------------------------------------------------------------------
  // Status, all derived from registered pointers
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  fill;
  logic [FW-1:0]  wr_free;
  logic [AVW-1:0] rd_avail;
  logic           wr_full;
  logic           rd_empty;
  logic           wr_accept;
  logic           rd_accept;

  // The wrap bit makes the modulo-2N difference the exact fill in slots.
  assign fill = wr_ptr_reg - rd_ptr_reg;

  // Free space counts only whole write words worth of empty slots. When a
  // wide write word is partially drained, its freed slots are not enough for
  // another write word and must not be reported as free.
  assign wr_free  = FW'((N_SLOTS - fill) >> WR_SH);

  // A partially packed read word is not counted.
  assign rd_avail = AVW'(fill >> RD_SH);

  assign wr_full  = (wr_free == '0);
  assign rd_empty = (rd_avail == '0);

  // Flush and reset swallow same-cycle requests. A read never unblocks a
  // write (and vice versa) because both decisions use start-of-cycle status.
  assign wr_accept = wr_en_i & ~wr_full  & ~flush_i & ~rst_i;
  assign rd_accept = rd_en_i & ~rd_empty & ~flush_i & ~rst_i;

  assign wr_full_o   = wr_full;
  assign wr_free_o   = wr_free;
  assign wr_afull_o  = (32'(wr_free) <= 32'(I_DEPTH - AF_LEVEL));
  assign rd_empty_o  = rd_empty;
  assign rd_avail_o  = rd_avail;
  assign rd_aempty_o = (32'(rd_avail) <= 32'(AE_LEVEL));
  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;

  // ---------------------------------------------------------------------------
  // Pointer and error-flag next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush_i) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_next = wr_ptr_reg + WR_STEP;
      end
      if (rd_accept) begin
        rd_ptr_next = rd_ptr_reg + RD_STEP;
      end
      if (wr_en_i && wr_full) begin
        overflow_next = 1'b1;
      end
      if (rd_en_i && rd_empty) begin
        underflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage banks
  // ---------------------------------------------------------------------------
  logic [AW-1:0]              wr_row;
  logic [AW-1:0]              rd_row;
  logic [LANES-1:0]           bank_we;
  logic [LANES-1:0][NW-1:0]   bank_wdata;
  logic [LANES-1:0][NW-1:0]   bank_rd;
  logic [O_WIDTH-1:0]         rd_word;

  // Row = slot address (wrap bit dropped) divided by the lane count.
  assign wr_row = AW'((wr_ptr_reg % N) / LANES);
  assign rd_row = AW'((rd_ptr_reg % N) / LANES);

  genvar gi;
  generate
    if (I_WIDTH >= O_WIDTH) begin : g_wide_wr
      // A write word fills a whole row; slice 0 goes to lane 0 so the
      // narrow reader sees the lowest slice first.
      for (gi = 0; gi < LANES; gi++) begin : g_lane_we
        assign bank_we[gi]    = wr_accept;
        assign bank_wdata[gi] = wr_data_i[gi*NW +: NW];
      end
    end else begin : g_narrow_wr
      // Successive narrow writes walk across the lanes of one row, which
      // gives little-endian packing in the wide read word.
      logic [LANE_W-1:0] wr_lane;
      assign wr_lane = LANE_W'(wr_ptr_reg % LANES);
      for (gi = 0; gi < LANES; gi++) begin : g_lane_we
        assign bank_we[gi]    = wr_accept && (wr_lane == LANE_W'(gi));
        assign bank_wdata[gi] = wr_data_i;
      end
    end

    for (gi = 0; gi < LANES; gi++) begin : g_bank
      logic [NW-1:0] mem [D];
      always_ff @(posedge clk_i) begin
        if (bank_we[gi]) begin
          mem[wr_row] <= bank_wdata[gi];
        end
      end
      assign bank_rd[gi] = mem[rd_row];
    end

    if (O_WIDTH >= I_WIDTH) begin : g_wide_rd
      assign rd_word = bank_rd;
    end else begin : g_narrow_rd
      logic [LANE_W-1:0] rd_lane;
      assign rd_lane = LANE_W'(rd_ptr_reg % LANES);
      assign rd_word = bank_rd[rd_lane];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read-side presentation
  // ---------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so the output
      // never exposes uninitialised storage (and is zero out of reset).
      assign rd_valid_o = ~rd_empty;
      assign rd_data_o  = rd_empty ? '0 : rd_word;
    end else begin : g_std
      logic               rd_valid_reg;
      logic [O_WIDTH-1:0] rd_data_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_valid_reg <= 1'b0;
          rd_data_reg  <= '0;
        end else if (flush_i) begin
          // Flush drops the valid strobe but leaves the data register alone.
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_accept;
          if (rd_accept) begin
            rd_data_reg <= rd_word;
          end
        end
      end
      assign rd_valid_o = rd_valid_reg;
      assign rd_data_o  = rd_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sc_wc.sv
// -----------------------------------------------------------------------------
// tb_fifo_sc_wc -- bench for fifo_sc_wc
//
// Two instances share one clock:
//   dut_a : 8 -> 32 packing, standard read, 16 x 8-bit write words
//   dut_b : 32 -> 8 unpacking, FWFT read, 4 x 32-bit write words
// The reference model holds the stored bytes in a queue (oldest first) and
// derives every status output from the queue length.
// -----------------------------------------------------------------------------
module tb_fifo_sc_wc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A signals ----------------
  logic        rst_a, flush_a, wr_en_a, rd_en_a;
  logic [7:0]  wr_data_a;
  logic        wr_full_a, wr_afull_a, rd_valid_a, rd_empty_a, rd_aempty_a;
  logic        overflow_a, underflow_a;
  logic [4:0]  wr_free_a;
  logic [31:0] rd_data_a;
  logic [2:0]  rd_avail_a;

  // ---------------- DUT B signals ----------------
  logic        rst_b, flush_b, wr_en_b, rd_en_b;
  logic [31:0] wr_data_b;
  logic        wr_full_b, wr_afull_b, rd_valid_b, rd_empty_b, rd_aempty_b;
  logic        overflow_b, underflow_b;
  logic [2:0]  wr_free_b;
  logic [7:0]  rd_data_b;
  logic [4:0]  rd_avail_b;

  fifo_sc_wc #(
    .I_WIDTH(8), .I_DEPTH(16), .O_WIDTH(32), .O_DEPTH(4), .FWFT(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .flush_i(flush_a),
    .wr_en_i(wr_en_a), .wr_data_i(wr_data_a),
    .wr_full_o(wr_full_a), .wr_free_o(wr_free_a), .wr_afull_o(wr_afull_a),
    .rd_en_i(rd_en_a), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a),
    .rd_empty_o(rd_empty_a), .rd_avail_o(rd_avail_a), .rd_aempty_o(rd_aempty_a),
    .overflow_o(overflow_a), .underflow_o(underflow_a)
  );

  fifo_sc_wc #(
    .I_WIDTH(32), .I_DEPTH(4), .O_WIDTH(8), .O_DEPTH(16), .FWFT(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .flush_i(flush_b),
    .wr_en_i(wr_en_b), .wr_data_i(wr_data_b),
    .wr_full_o(wr_full_b), .wr_free_o(wr_free_b), .wr_afull_o(wr_afull_b),
    .rd_en_i(rd_en_b), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b),
    .rd_empty_o(rd_empty_b), .rd_avail_o(rd_avail_b), .rd_aempty_o(rd_aempty_b),
    .overflow_o(overflow_b), .underflow_o(underflow_b)
  );

  // ---------------- reference model state ----------------
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  bit          m_ovf_a, m_unf_a, m_val_a;
  logic [31:0] m_data_a;
  bit          m_ovf_b, m_unf_b;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: 8-bit writes, 32-bit reads ----------------
  task automatic check_a();
    int free, avail;
    free  = 16 - qa.size();
    avail = qa.size() / 4;
    check("A.wr_free",   32'(wr_free_a),   32'(free));
    check("A.wr_full",   32'(wr_full_a),   32'(free == 0));
    check("A.wr_afull",  32'(wr_afull_a),  32'(free <= 2));
    check("A.rd_avail",  32'(rd_avail_a),  32'(avail));
    check("A.rd_empty",  32'(rd_empty_a),  32'(avail == 0));
    check("A.rd_aempty", 32'(rd_aempty_a), 32'(avail <= 1));
    check("A.rd_valid",  32'(rd_valid_a),  32'(m_val_a));
    check("A.rd_data",   rd_data_a,        m_data_a);
    check("A.overflow",  32'(overflow_a),  32'(m_ovf_a));
    check("A.underflow", 32'(underflow_a), 32'(m_unf_a));
  endtask

  task automatic cyc_a(input bit w, input logic [7:0] d, input bit r, input bit fl, input bit rs);
    int  free, avail;
    free  = 16 - qa.size();
    avail = qa.size() / 4;
    rst_a = rs; flush_a = fl; wr_en_a = w; wr_data_a = d; rd_en_a = r;
    @(posedge clk); #1;
    rst_a = 1'b0; flush_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0;
    if (rs) begin
      qa.delete(); m_ovf_a = 0; m_unf_a = 0; m_val_a = 0; m_data_a = '0;
    end else if (fl) begin
      qa.delete(); m_ovf_a = 0; m_unf_a = 0; m_val_a = 0;
    end else begin
      if (w && free == 0)  m_ovf_a = 1;
      if (r && avail == 0) m_unf_a = 1;
      m_val_a = r && (avail > 0);
      if (m_val_a) begin
        m_data_a = {qa[3], qa[2], qa[1], qa[0]};
        repeat (4) void'(qa.pop_front());
      end
      if (w && free > 0) qa.push_back(d);
    end
    $display("A wr=%0d d=%02h rd=%0d flush=%0d rst=%0d -> bytes=%0d data=%08h valid=%0d",
             w, d, r, fl, rs, qa.size(), rd_data_a, rd_valid_a);
    check_a();
  endtask

  // ---------------- DUT B: 32-bit writes, 8-bit FWFT reads ----------------
  task automatic check_b();
    int free, avail;
    free  = (16 - qb.size()) / 4;
    avail = qb.size();
    check("B.wr_free",   32'(wr_free_b),   32'(free));
    check("B.wr_full",   32'(wr_full_b),   32'(free == 0));
    check("B.wr_afull",  32'(wr_afull_b),  32'(free <= 2));
    check("B.rd_avail",  32'(rd_avail_b),  32'(avail));
    check("B.rd_empty",  32'(rd_empty_b),  32'(avail == 0));
    check("B.rd_aempty", 32'(rd_aempty_b), 32'(avail <= 1));
    check("B.rd_valid",  32'(rd_valid_b),  32'(avail > 0));
    if (avail > 0) check("B.rd_data", 32'(rd_data_b), 32'(qb[0]));
    check("B.overflow",  32'(overflow_b),  32'(m_ovf_b));
    check("B.underflow", 32'(underflow_b), 32'(m_unf_b));
  endtask

  task automatic cyc_b(input bit w, input logic [31:0] d, input bit r, input bit fl, input bit rs);
    int free, avail;
    free  = (16 - qb.size()) / 4;
    avail = qb.size();
    rst_b = rs; flush_b = fl; wr_en_b = w; wr_data_b = d; rd_en_b = r;
    @(posedge clk); #1;
    rst_b = 1'b0; flush_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
    if (rs || fl) begin
      qb.delete(); m_ovf_b = 0; m_unf_b = 0;
    end else begin
      if (w && free == 0)  m_ovf_b = 1;
      if (r && avail == 0) m_unf_b = 1;
      if (r && avail > 0)  void'(qb.pop_front());
      if (w && free > 0) begin
        for (int k = 0; k < 4; k++) qb.push_back(d[8*k +: 8]);
      end
    end
    $display("B wr=%0d d=%08h rd=%0d flush=%0d rst=%0d -> bytes=%0d data=%02h valid=%0d",
             w, d, r, fl, rs, qb.size(), rd_data_b, rd_valid_b);
    check_b();
  endtask

  initial begin
    logic [7:0] nb;
    rst_a = 1'b0; flush_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0; wr_data_a = '0;
    rst_b = 1'b0; flush_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0; wr_data_b = '0;

    // ---- reset state of both instances ----
    cyc_b(0, 32'h0, 0, 0, 1);
    check("B.rd_data_rst", 32'(rd_data_b), 32'h0);
    cyc_a(0, 8'h00, 0, 0, 1);

    // ---- A: packing, partial word not counted, one-cycle valid ----
    cyc_a(1, 8'h11, 0, 0, 0);
    cyc_a(1, 8'h22, 0, 0, 0);
    cyc_a(1, 8'h33, 0, 0, 0);
    cyc_a(1, 8'h44, 0, 0, 0);
    cyc_a(0, 8'h00, 1, 0, 0);
    check("A.first_word", rd_data_a, 32'h44332211);
    cyc_a(0, 8'h00, 0, 0, 0);

    // ---- A: fill to full, overflow, drain, underflow ----
    for (int i = 1; i <= 16; i++) cyc_a(1, 8'(i), 0, 0, 0);
    cyc_a(1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc_a(0, 8'h00, 1, 0, 0);

    // ---- A: flush with two words stored and a same-cycle write ----
    for (int i = 0; i < 8; i++) cyc_a(1, 8'(8'hC0 + i), 0, 0, 0);
    cyc_a(1, 8'h99, 0, 1, 0);

    // ---- A: three fill/drain rounds across pointer wrap ----
    nb = 8'h00;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 16; i++) begin
        cyc_a(1, nb, 0, 0, 0);
        nb = nb + 8'd1;
      end
      for (int i = 0; i < 4; i++) cyc_a(0, 8'h00, 1, 0, 0);
    end

    // ---- A: simultaneous write and read at a fill of 8 bytes ----
    for (int i = 0; i < 8; i++) cyc_a(1, 8'(8'h50 + i), 0, 0, 0);
    cyc_a(1, 8'h58, 1, 0, 0);
    cyc_a(1, 8'h59, 1, 0, 0);

    // ---- A: randomized traffic, fill-biased then drain-biased ----
    for (int i = 0; i < 150; i++)
      cyc_a($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
            $urandom_range(0, 59) == 0, 0);
    for (int i = 0; i < 150; i++)
      cyc_a($urandom_range(0, 9) < 5, 8'($urandom), $urandom_range(0, 9) < 3,
            $urandom_range(0, 59) == 0, 0);

    // ---- A: reset mid-stream with flush also high, then clean restart ----
    for (int i = 0; i < 5; i++) cyc_a(1, 8'(8'h70 + i), 0, 0, 0);
    cyc_a(1, 8'hEE, 1, 1, 1);
    for (int i = 0; i < 4; i++) cyc_a(1, 8'(8'hA0 + i), 0, 0, 0);
    cyc_a(0, 8'h00, 1, 0, 0);
    check("A.after_reset_word", rd_data_a, 32'hA3A2A1A0);

    // ---- B: unpacking in FWFT mode ----
    cyc_b(1, 32'hDDCCBBAA, 0, 0, 0);
    check("B.fwft_first", 32'(rd_data_b), 32'hAA);
    for (int i = 0; i < 4; i++) cyc_b(0, 32'h0, 1, 0, 0);

    // ---- B: fill, overflow, drain, underflow, flush ----
    for (int i = 0; i < 5; i++) cyc_b(1, 32'h03020100 + 32'(i) * 32'h04040404, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc_b(0, 32'h0, 1, 0, 0);
    cyc_b(1, 32'h12345678, 0, 0, 0);
    cyc_b(1, 32'h9ABCDEF0, 1, 0, 0);
    for (int i = 0; i < 14; i++) cyc_b(0, 32'h0, 1, 0, 0);
    cyc_b(1, 32'h55667788, 0, 0, 0);
    cyc_b(1, 32'h11223344, 0, 1, 0);

    // ---- B: randomized traffic ----
    for (int i = 0; i < 250; i++)
      cyc_b($urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 79) == 0, 0);

    // ---- B: reset mid-stream with flush high, then clean restart ----
    cyc_b(1, 32'hCAFEF00D, 0, 0, 0);
    cyc_b(1, 32'hCAFEF00D, 1, 1, 1);
    check("B.rd_data_rst2", 32'(rd_data_b), 32'h0);
    cyc_b(1, 32'h04030201, 0, 0, 0);
    check("B.after_reset_byte", 32'(rd_data_b), 32'h01);
    for (int i = 0; i < 4; i++) cyc_b(0, 32'h0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
